seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Time-multiplexed display scanner. It sits directly downstream of the per-digit seven-segment decoders.
- Takes NDIG packed 8-bit segment patterns plus per-digit enables and drives one shared segment bus and one-hot active-low digit selects.
- Cycles through the digits with a programmable dwell time and a blanking guard between digits, which suppresses ghosting.
- Captures a whole frame at its start so digits cannot tear mid-frame.

Parameters:
- NDIG, 8, number of digits scanned (>=2).
- DIV, 50000, SHOW dwell per digit in clk cycles (>=1).
- GUARD, 4, BLANK cycles before each digit (>=1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  NDIG*8  packed segment patterns; digit k in bits [8k+7:8k]; active-low segments; passed through unmodified.
- en_in  input  NDIG  per-digit enable; 0 = digit blanked for that frame.
- seg_out  output  8  shared segment bus; 8'hFF = all segments off.
- an_out  output  NDIG  digit select, active-low, at most one bit low.
- scan_idx  output  $clog2(NDIG)  index of the digit currently owned by the scanner.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - state=LOAD, scan_idx=0, dwell and guard counters=0.
  - seg_out=8'hFF, an_out=all 1s, frame_done=0.
  - Frame buffer: all patterns 8'hFF, all enables 0.
- All outputs are registered and reflect the current state.
- FSM states: LOAD, BLANK, SHOW.
- LOAD (exactly 1 cycle, only entered with scan_idx=0):
  - Frame buffer <= seg_in and en_in.
  - Outputs blank.
  - Next state BLANK, guard=0.
- BLANK:
  - an_out all 1s, seg_out 8'hFF.
  - guard increments each cycle. When guard==GUARD-1, go to SHOW and clear dwell.
  - Lasts exactly GUARD cycles.
- SHOW:
  - If buf_en[scan_idx]=1: an_out has only bit scan_idx low; seg_out=buf_seg[scan_idx].
  - Otherwise: an_out all 1s and seg_out 8'hFF.
  - dwell increments each cycle. When dwell==DIV-1:
    - If scan_idx<NDIG-1: scan_idx+1, go to BLANK.
    - Else: scan_idx wraps to 0, go to LOAD, and frame_done=1 during that LOAD cycle.
- frame_done is high only in a LOAD cycle that follows SHOW of digit NDIG-1. It is 0 in the first LOAD after reset.
- Timing:
  - Per-digit slot = GUARD+DIV cycles.
  - Frame period = NDIG*(GUARD+DIV)+1 cycles.
  - First LOAD is the cycle in which rst is first sampled low.
- Input updates: seg_in and en_in are sampled only in LOAD. Changes mid-frame take effect at the next frame.
- Reset asserted in any state: on the next edge, all registers return to their reset values and any in-progress frame is discarded.
- Overlap guarantee: no cycle exists in which two an_out bits are low. an_out changes only via an all-1s BLANK cycle.
- Counter widths: sized for DIV-1 and GUARD-1. No wrap-around other than the explicit terminal compares.

Test Plan:
Parameters for all scenarios: NDIG=4, DIV=4, GUARD=2, so frame = 25 cycles.
1. Hold rst high 3 cycles -> seg_out=8'hFF, an_out=4'b1111, scan_idx=0, frame_done=0 throughout.
2. Release rst with seg_in=32'h99_B0_A4_F9 and en_in=4'b1111 -> sequence is:
   - 1 LOAD cycle, then 2 BLANK cycles.
   - 4 cycles of an_out=4'b1110, seg_out=8'hF9.
   - 2 BLANK, then 4 cycles of 4'b1101 / 8'hA4.
   - 2 BLANK, then 4 cycles of 4'b1011 / 8'hB0.
   - 2 BLANK, then 4 cycles of 4'b0111 / 8'h99.
   - Then LOAD with frame_done=1.
3. en_in=4'b1011 at LOAD -> during digit-2 SHOW cycles an_out=4'b1111 and seg_out=8'hFF. The other digits display normally.
4. Change seg_in[7:0] to 8'hC0 during digit-1 SHOW:
   - Digit 0 shows 8'hF9 for the rest of this frame.
   - Digit 0 shows 8'hC0 from the next frame.
5. Free-run 4 frames -> frame_done pulses exactly 1 cycle, every 25 cycles. Monitor confirms popcount(~an_out)<=1 every cycle.
6. Assert rst for 1 cycle during digit-2 SHOW:
   - Next cycle: outputs are reset values and scan_idx=0.
   - After release: LOAD, then 2 BLANK cycles, then digit-0 SHOW, with no frame_done pulse.

Source files
------------

// File: rtl/seg_scan.sv
`timescale 1ns/1ps
// seg_scan: time-multiplexed seven-segment scanner.
// Captures a whole frame (NDIG segment patterns + enables) in a one-cycle LOAD
// state, then for every digit spends GUARD cycles blanked and DIV cycles
// showing that digit. A blank slot between digits keeps two anodes from ever
// being low together and suppresses ghosting.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous active-high reset
//   seg_in     NDIG*8 packed active-low segment patterns, digit k in [8k+7:8k]
//   en_in      per-digit enable, 0 = digit blanked for the frame
//   seg_out    shared segment bus, 8'hFF = all off
//   an_out     active-low one-hot digit select (all 1s when blank)
//   scan_idx   digit currently owned by the scanner
//   frame_done one-cycle pulse in the LOAD that ends a frame
module seg_scan #(
  parameter int NDIG  = 8,
  parameter int DIV   = 50000,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NDIG*8-1:0]       seg_in,
  input  logic [NDIG-1:0]         en_in,
  output logic [7:0]              seg_out,
  output logic [NDIG-1:0]         an_out,
  output logic [$clog2(NDIG)-1:0] scan_idx,
  output logic                    frame_done
);

  localparam int IW = $clog2(NDIG);
  localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG - 1);
  localparam logic [DW-1:0] DWELL_END = DW'(DIV - 1);
  localparam logic [GW-1:0] GUARD_END = GW'(GUARD - 1);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]             state, nxt_state;
  logic [IW-1:0]          nxt_idx;
  logic [DW-1:0]          dwell, nxt_dwell;
  logic [GW-1:0]          guard, nxt_guard;
  logic [NDIG-1:0][7:0]   buf_seg;
  logic [NDIG-1:0]        buf_en;
  logic [7:0]             nxt_seg;
  logic [NDIG-1:0]        nxt_an;
  logic                   nxt_fd;

  // Next-state / counter logic.
  always_comb begin
    nxt_state = state;
    nxt_idx   = scan_idx;
    nxt_dwell = dwell;
    nxt_guard = guard;
    nxt_fd    = 1'b0;
    case (state)
      LOAD: begin
        nxt_state = BLANK;
        nxt_guard = '0;
        nxt_idx   = '0;
      end
      BLANK: begin
        if (guard == GUARD_END) begin
          nxt_state = SHOW;
          nxt_dwell = '0;
        end else begin
          nxt_guard = guard + GW'(1);
        end
      end
      SHOW: begin
        if (dwell == DWELL_END) begin
          if (scan_idx == LAST_IDX) begin
            nxt_idx   = '0;
            nxt_state = LOAD;
            nxt_fd    = 1'b1;
          end else begin
            nxt_idx   = scan_idx + IW'(1);
            nxt_state = BLANK;
            nxt_guard = '0;
          end
        end else begin
          nxt_dwell = dwell + DW'(1);
        end
      end
      default: begin
        nxt_state = LOAD;
        nxt_idx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the *next* state so the registered outputs line
  // up with the state register in the same cycle. The frame buffer is never
  // written on a transition into SHOW, so reading it here is safe.
  always_comb begin
    nxt_seg = 8'hFF;
    nxt_an  = '1;
    if (nxt_state == SHOW && buf_en[nxt_idx]) begin
      nxt_an[nxt_idx] = 1'b0;
      nxt_seg         = buf_seg[nxt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      scan_idx   <= '0;
      dwell      <= '0;
      guard      <= '0;
      seg_out    <= 8'hFF;
      an_out     <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      scan_idx   <= nxt_idx;
      dwell      <= nxt_dwell;
      guard      <= nxt_guard;
      seg_out    <= nxt_seg;
      an_out     <= nxt_an;
      frame_done <= nxt_fd;
    end
  end

  // Frame buffer: packed layout matches seg_in, so a whole-word copy keeps
  // digit k in element k. Only LOAD writes it, which prevents mid-frame tearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_seg <= '1;
      buf_en  <= '0;
    end else if (state == LOAD) begin
      buf_seg <= seg_in;
      buf_en  <= en_in;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
`timescale 1ns/1ps
module tb_seg_scan;

  localparam int NDIG = 4, DIV = 4, GUARD = 2, FRAME = 25;

  logic        clk, rst;
  logic [31:0] seg_in;
  logic [3:0]  en_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic [1:0]  scan_idx;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  seg_scan #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .en_in(en_in),
    .seg_out(seg_out), .an_out(an_out), .scan_idx(scan_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs for one whole frame, starting with its LOAD cycle.
  task automatic push_frame(input logic [31:0] s, input logic [3:0] en, input logic fd);
    exp_t x;
    x = '{seg: 8'hFF, an: 4'hF, idx: 2'd0, fd: fd};
    sb.push_back(x);
    for (int k = 0; k < NDIG; k++) begin
      repeat (GUARD) begin
        x = '{seg: 8'hFF, an: 4'hF, idx: 2'(k), fd: 1'b0};
        sb.push_back(x);
      end
      repeat (DIV) begin
        if (en[k]) x = '{seg: s[8*k +: 8], an: ~(4'b0001 << k), idx: 2'(k), fd: 1'b0};
        else       x = '{seg: 8'hFF, an: 4'hF, idx: 2'(k), fd: 1'b0};
        sb.push_back(x);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
        fails++;
        $display("FAIL reset: got seg=%h an=%b idx=%0d fd=%b, exp seg=ff an=1111 idx=0 fd=0",
                 seg_out, an_out, scan_idx, frame_done);
      end
    end
  endtask

  task automatic test_frame();
    seg_in = 32'h99_B0_A4_F9;
    en_in  = 4'b1111;
    push_frame(seg_in, en_in, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL frame cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_enable();
    en_in = 4'b1011;
    push_frame(seg_in, en_in, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL enable cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_input_update();
    logic [31:0] s_new;
    en_in = 4'b1111;
    push_frame(seg_in, en_in, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL update_old cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
      if (i == 10) seg_in[7:0] = 8'hC0;   // during digit-1 SHOW
    end
    @(posedge clk); #1;
    s_new = 32'h99_B0_A4_C0;
    push_frame(s_new, en_in, 1'b1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL update_new cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
      if (i == 3) begin
        tests++;
        if (seg_out !== 8'hC0) begin
          fails++;
          $display("FAIL update_digit0: got seg=%h exp seg=c0", seg_out);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int pulses, last;
    pulses = 0;
    last   = -1;
    seg_in = 32'h82_92_99_B0;
    repeat (4) push_frame(seg_in, en_in, 1'b1);
    for (int i = 0; i < 4*FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL freerun cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
      if (frame_done) begin
        if (last >= 0) begin
          tests++;
          if (i - last !== FRAME) begin
            fails++;
            $display("FAIL fd_period: got %0d exp %0d", i - last, FRAME);
          end
        end
        last = i;
        pulses++;
      end
    end
    tests++;
    if (pulses !== 4) begin
      fails++;
      $display("FAIL fd_count: got %0d exp 4", pulses);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    seg_in = 32'h99_B0_A4_F9;
    push_frame(seg_in, en_in, 1'b1);
    // Consume only up to the first digit-2 SHOW cycle, then reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e) begin
        fails++;
        $display("FAIL pre_reset cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
    end
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({seg_out, an_out, scan_idx, frame_done} !== {8'hFF, 4'hF, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got seg=%h an=%b idx=%0d fd=%b, exp seg=ff an=1111 idx=0 fd=0",
               seg_out, an_out, scan_idx, frame_done);
    end
    rst = 1'b0;
    push_frame(seg_in, en_in, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if ({seg_out, an_out, scan_idx, frame_done} !== e || $countones(~an_out) > 1) begin
        fails++;
        $display("FAIL post_reset cyc%0d: got %h exp %h", i, {seg_out, an_out, scan_idx, frame_done}, e);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    seg_in = 32'hFFFF_FFFF;
    en_in  = 4'b0000;
    test_reset();
    test_frame();
    test_enable();
    test_input_update();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d left exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
